// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - pipeline stall arbitration and machine-mode trap sequencing
module trap_ctrl #(
  parameter int               XLEN          = 32,
  parameter int               NUM_LOCAL_IRQ = 4,
  parameter logic [XLEN-1:0]  RESET_PC      = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                exception_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [XLEN-1:0]           ins_i,
  input  logic [XLEN-1:0]           mem_addr_i,
  input  logic                      stallreq_if_i,
  input  logic                      stallreq_id_i,
  input  logic                      stallreq_ex_i,
  input  logic                      stallreq_mem_i,
  input  logic                      mstatus_ie_i,
  input  logic [16+NUM_LOCAL_IRQ-1:0] mie_i,
  input  logic [16+NUM_LOCAL_IRQ-1:0] mip_i,
  input  logic [XLEN-1:0]           mtvec_i,
  input  logic [XLEN-1:0]           epc_i,
  output logic                      ie_type_o,
  output logic                      set_cause_o,
  output logic [4:0]                trap_cause_o,
  output logic                      set_epc_o,
  output logic [XLEN-1:0]           epc_o,
  output logic                      set_mtval_o,
  output logic [XLEN-1:0]           mtval_o,
  output logic                      mstatus_ie_clear_o,
  output logic                      mstatus_ie_set_o,
  output logic [5:0]                stall_o,
  output logic                      flush_o,
  output logic [XLEN-1:0]           new_pc_o,
  output logic                      wfi_sleep_o
);

  localparam int IRQW = 16 + NUM_LOCAL_IRQ;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_OPERATING,
    ST_TRAP_TAKEN,
    ST_TRAP_RETURN,
    ST_WFI
  } state_t;

  state_t state_q, state_d;

  logic            ie_type_q;
  logic [4:0]      cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] mtval_q;
  logic            mtval_valid_q;

  logic ex_wfi, ex_ld, ex_st, ex_ill, ex_mi, ex_ebrk, ex_ecall, ex_mret;
  assign {ex_wfi, ex_ld, ex_st, ex_ill, ex_mi, ex_ebrk, ex_ecall, ex_mret} = exception_i;

  logic [IRQW-1:0] ip_m;
  logic            irq_any;
  logic            irq_take;
  logic [4:0]      irq_cause;

  // Only MSI/MTI/MEI and the local lines are architected; the rest are masked off.
  always_comb begin
    ip_m       = mie_i & mip_i;
    ip_m[15:0] = ip_m[15:0] & 16'h0888;
    irq_any    = |ip_m;
    irq_cause  = 5'd0;
    // Lowest priority assigned first so later hits override.
    if (ip_m[7])  irq_cause = 5'd7;
    if (ip_m[3])  irq_cause = 5'd3;
    if (ip_m[11]) irq_cause = 5'd11;
    for (int k = 0; k < NUM_LOCAL_IRQ; k++) begin
      if (ip_m[16+k]) irq_cause = 5'(16 + k);
    end
  end

  assign irq_take = mstatus_ie_i & irq_any;

  logic            exc_any;
  logic [4:0]      exc_cause;
  logic [XLEN-1:0] exc_mtval;
  logic            exc_mtval_valid;

  assign exc_any = |exception_i[6:1];

  always_comb begin
    exc_cause       = 5'd0;
    exc_mtval       = '0;
    exc_mtval_valid = 1'b0;
    if (ex_mi) begin
      exc_cause = 5'd0;  exc_mtval = pc_i;       exc_mtval_valid = 1'b1;
    end else if (ex_ill) begin
      exc_cause = 5'd2;  exc_mtval = ins_i;      exc_mtval_valid = 1'b1;
    end else if (ex_ebrk) begin
      exc_cause = 5'd3;  exc_mtval = pc_i;       exc_mtval_valid = 1'b1;
    end else if (ex_ecall) begin
      exc_cause = 5'd11;
    end else if (ex_ld) begin
      exc_cause = 5'd4;  exc_mtval = mem_addr_i; exc_mtval_valid = 1'b1;
    end else if (ex_st) begin
      exc_cause = 5'd6;  exc_mtval = mem_addr_i; exc_mtval_valid = 1'b1;
    end
  end

  logic trap;
  assign trap = irq_take | exc_any;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:       state_d = ST_OPERATING;
      ST_OPERATING: begin
        if (trap)        state_d = ST_TRAP_TAKEN;
        else if (ex_mret) state_d = ST_TRAP_RETURN;
        else if (ex_wfi)  state_d = ST_WFI;
      end
      ST_TRAP_TAKEN:  state_d = ST_OPERATING;
      ST_TRAP_RETURN: state_d = ST_OPERATING;
      ST_WFI:         if (irq_any) state_d = ST_OPERATING;
      default:        state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RESET;
      ie_type_q     <= 1'b0;
      cause_q       <= 5'd0;
      epc_q         <= '0;
      mtval_q       <= '0;
      mtval_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_OPERATING && trap) begin
        epc_q <= pc_i;
        if (irq_take) begin
          ie_type_q     <= 1'b1;
          cause_q       <= irq_cause;
          mtval_q       <= '0;
          mtval_valid_q <= 1'b0;
        end else begin
          ie_type_q     <= 1'b0;
          cause_q       <= exc_cause;
          mtval_q       <= exc_mtval;
          mtval_valid_q <= exc_mtval_valid;
        end
      end
    end
  end

  assign ie_type_o    = ie_type_q;
  assign trap_cause_o = cause_q;
  assign epc_o        = epc_q;
  assign mtval_o      = mtval_q;

  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_off;
  assign trap_base = mtvec_i & ~XLEN'(3);
  assign trap_off  = (mtvec_i[0] && ie_type_q) ? {{(XLEN-7){1'b0}}, cause_q, 2'b00} : '0;

  always_comb begin
    set_cause_o        = 1'b0;
    set_epc_o          = 1'b0;
    set_mtval_o        = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    flush_o            = 1'b0;
    new_pc_o           = '0;
    stall_o            = 6'b000000;
    wfi_sleep_o        = 1'b0;
    case (state_q)
      ST_RESET: begin
        flush_o  = 1'b1;
        new_pc_o = RESET_PC;
      end
      ST_TRAP_TAKEN: begin
        flush_o            = 1'b1;
        set_cause_o        = 1'b1;
        set_epc_o          = 1'b1;
        set_mtval_o        = mtval_valid_q;
        mstatus_ie_clear_o = 1'b1;
        new_pc_o           = trap_base + trap_off;
      end
      ST_TRAP_RETURN: begin
        flush_o          = 1'b1;
        mstatus_ie_set_o = 1'b1;
        new_pc_o         = epc_i;
      end
      ST_WFI: begin
        stall_o     = 6'b011111;
        wfi_sleep_o = 1'b1;
      end
      ST_OPERATING: begin
        if (stallreq_mem_i)      stall_o = 6'b011111;
        else if (stallreq_ex_i)  stall_o = 6'b001111;
        else if (stallreq_id_i)  stall_o = 6'b000111;
        else if (stallreq_if_i)  stall_o = 6'b000111;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

  localparam int          XLEN     = 32;
  localparam int          NLI      = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [7:0]      exception_i;
  logic [31:0]     pc_i, ins_i, mem_addr_i, mtvec_i, epc_i;
  logic            stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic            mstatus_ie_i;
  logic [19:0]     mie_i, mip_i;
  logic            ie_type_o, set_cause_o, set_epc_o, set_mtval_o;
  logic [4:0]      trap_cause_o;
  logic [31:0]     epc_o, mtval_o, new_pc_o;
  logic            mstatus_ie_clear_o, mstatus_ie_set_o, flush_o, wfi_sleep_o;
  logic [5:0]      stall_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.XLEN(XLEN), .NUM_LOCAL_IRQ(NLI), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .exception_i(exception_i), .pc_i(pc_i), .ins_i(ins_i),
    .mem_addr_i(mem_addr_i), .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i), .mstatus_ie_i(mstatus_ie_i),
    .mie_i(mie_i), .mip_i(mip_i), .mtvec_i(mtvec_i), .epc_i(epc_i), .ie_type_o(ie_type_o),
    .set_cause_o(set_cause_o), .trap_cause_o(trap_cause_o), .set_epc_o(set_epc_o), .epc_o(epc_o),
    .set_mtval_o(set_mtval_o), .mtval_o(mtval_o), .mstatus_ie_clear_o(mstatus_ie_clear_o),
    .mstatus_ie_set_o(mstatus_ie_set_o), .stall_o(stall_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .wfi_sleep_o(wfi_sleep_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL rst_flush: got %h exp 1", flush_o); end
    vec_cnt++; if (new_pc_o !== RESET_PC) begin err_cnt++; $display("FAIL rst_newpc: got %h exp %h", new_pc_o, RESET_PC); end
    vec_cnt++; if (epc_o !== 32'h0) begin err_cnt++; $display("FAIL rst_epc: got %h exp 0", epc_o); end
    vec_cnt++; if (mtval_o !== 32'h0) begin err_cnt++; $display("FAIL rst_mtval: got %h exp 0", mtval_o); end
    vec_cnt++; if (set_cause_o !== 1'b0) begin err_cnt++; $display("FAIL rst_setcause: got %h exp 0", set_cause_o); end
    rst_i = 1'b0;
    #1;
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL rel_flush: got %h exp 1", flush_o); end
    vec_cnt++; if (new_pc_o !== RESET_PC) begin err_cnt++; $display("FAIL rel_newpc: got %h exp %h", new_pc_o, RESET_PC); end
    tick();
    vec_cnt++; if (flush_o !== 1'b0) begin err_cnt++; $display("FAIL op_flush: got %h exp 0", flush_o); end
    // Reset in the middle of a trap.
    exception_i = 8'h10; pc_i = 32'h44; ins_i = 32'h1234;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (set_cause_o !== 1'b1) begin err_cnt++; $display("FAIL mid_pre_setcause: got %h exp 1", set_cause_o); end
    rst_i = 1'b1;
    #1;
    vec_cnt++; if (set_cause_o !== 1'b0) begin err_cnt++; $display("FAIL mid_setcause: got %h exp 0", set_cause_o); end
    vec_cnt++; if (set_epc_o !== 1'b0) begin err_cnt++; $display("FAIL mid_setepc: got %h exp 0", set_epc_o); end
    vec_cnt++; if (mstatus_ie_clear_o !== 1'b0) begin err_cnt++; $display("FAIL mid_ieclr: got %h exp 0", mstatus_ie_clear_o); end
    vec_cnt++; if (trap_cause_o !== 5'd0) begin err_cnt++; $display("FAIL mid_cause: got %h exp 0", trap_cause_o); end
    vec_cnt++; if (epc_o !== 32'h0) begin err_cnt++; $display("FAIL mid_epc: got %h exp 0", epc_o); end
    vec_cnt++; if (new_pc_o !== RESET_PC) begin err_cnt++; $display("FAIL mid_newpc: got %h exp %h", new_pc_o, RESET_PC); end
    rst_i = 1'b0;
    tick();
    vec_cnt++; if (flush_o !== 1'b0) begin err_cnt++; $display("FAIL mid_rel_flush: got %h exp 0", flush_o); end
  endtask

  task automatic test_direct();
    mtvec_i = 32'h100; exception_i = 8'h10; pc_i = 32'h80; ins_i = 32'hFFFF_FFFF;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL dir_flush: got %h exp 1", flush_o); end
    vec_cnt++; if (new_pc_o !== 32'h100) begin err_cnt++; $display("FAIL dir_newpc: got %h exp 100", new_pc_o); end
    vec_cnt++; if (trap_cause_o !== 5'd2) begin err_cnt++; $display("FAIL dir_cause: got %0d exp 2", trap_cause_o); end
    vec_cnt++; if (ie_type_o !== 1'b0) begin err_cnt++; $display("FAIL dir_ietype: got %h exp 0", ie_type_o); end
    vec_cnt++; if (epc_o !== 32'h80) begin err_cnt++; $display("FAIL dir_epc: got %h exp 80", epc_o); end
    vec_cnt++; if (mtval_o !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dir_mtval: got %h exp ffffffff", mtval_o); end
    vec_cnt++; if (set_mtval_o !== 1'b1) begin err_cnt++; $display("FAIL dir_setmtval: got %h exp 1", set_mtval_o); end
    vec_cnt++; if (mstatus_ie_clear_o !== 1'b1) begin err_cnt++; $display("FAIL dir_ieclr: got %h exp 1", mstatus_ie_clear_o); end
    vec_cnt++; if (set_epc_o !== 1'b1) begin err_cnt++; $display("FAIL dir_setepc: got %h exp 1", set_epc_o); end
    tick();
    vec_cnt++; if (flush_o !== 1'b0) begin err_cnt++; $display("FAIL dir_after_flush: got %h exp 0", flush_o); end
    vec_cnt++; if (set_mtval_o !== 1'b0) begin err_cnt++; $display("FAIL dir_after_setmtval: got %h exp 0", set_mtval_o); end
    vec_cnt++; if (mtval_o !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dir_hold_mtval: got %h exp ffffffff", mtval_o); end
  endtask

  task automatic test_vectored();
    mtvec_i = 32'h201; pc_i = 32'h90; mstatus_ie_i = 1'b0;
    mie_i = 20'h2_0880; mip_i = 20'h2_0880;
    tick();
    vec_cnt++; if (flush_o !== 1'b0) begin err_cnt++; $display("FAIL vec_masked_flush: got %h exp 0", flush_o); end
    vec_cnt++; if (trap_cause_o !== 5'd2) begin err_cnt++; $display("FAIL vec_masked_cause: got %0d exp 2", trap_cause_o); end
    mstatus_ie_i = 1'b1;
    tick();
    mstatus_ie_i = 1'b0;
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL vec_flush: got %h exp 1", flush_o); end
    vec_cnt++; if (trap_cause_o !== 5'd17) begin err_cnt++; $display("FAIL vec_cause: got %0d exp 17", trap_cause_o); end
    vec_cnt++; if (ie_type_o !== 1'b1) begin err_cnt++; $display("FAIL vec_ietype: got %h exp 1", ie_type_o); end
    vec_cnt++; if (new_pc_o !== 32'h244) begin err_cnt++; $display("FAIL vec_newpc: got %h exp 244", new_pc_o); end
    vec_cnt++; if (set_mtval_o !== 1'b0) begin err_cnt++; $display("FAIL vec_setmtval: got %h exp 0", set_mtval_o); end
    vec_cnt++; if (mtval_o !== 32'h0) begin err_cnt++; $display("FAIL vec_mtval: got %h exp 0", mtval_o); end
    vec_cnt++; if (epc_o !== 32'h90) begin err_cnt++; $display("FAIL vec_epc: got %h exp 90", epc_o); end
    tick();
    // Software (3) beats timer (7); ignored bit 1 must not matter.
    mie_i = 20'h0_008A; mip_i = 20'h0_008A; mstatus_ie_i = 1'b1;
    tick();
    mstatus_ie_i = 1'b0; mie_i = '0; mip_i = '0;
    vec_cnt++; if (trap_cause_o !== 5'd3) begin err_cnt++; $display("FAIL vec_sw_cause: got %0d exp 3", trap_cause_o); end
    vec_cnt++; if (new_pc_o !== 32'h20C) begin err_cnt++; $display("FAIL vec_sw_newpc: got %h exp 20c", new_pc_o); end
    tick();
  endtask

  task automatic test_simultaneous();
    exception_i = 8'h03; pc_i = 32'hA0;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (trap_cause_o !== 5'd11) begin err_cnt++; $display("FAIL sim_ecall_cause: got %0d exp 11", trap_cause_o); end
    vec_cnt++; if (set_cause_o !== 1'b1) begin err_cnt++; $display("FAIL sim_ecall_setcause: got %h exp 1", set_cause_o); end
    vec_cnt++; if (mstatus_ie_set_o !== 1'b0) begin err_cnt++; $display("FAIL sim_ecall_ieset: got %h exp 0", mstatus_ie_set_o); end
    vec_cnt++; if (new_pc_o !== 32'h200) begin err_cnt++; $display("FAIL sim_ecall_newpc: got %h exp 200", new_pc_o); end
    vec_cnt++; if (set_mtval_o !== 1'b0) begin err_cnt++; $display("FAIL sim_ecall_setmtval: got %h exp 0", set_mtval_o); end
    tick();
    exception_i = 8'h40; mem_addr_i = 32'h1003; pc_i = 32'hA4;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (trap_cause_o !== 5'd4) begin err_cnt++; $display("FAIL sim_ld_cause: got %0d exp 4", trap_cause_o); end
    vec_cnt++; if (mtval_o !== 32'h1003) begin err_cnt++; $display("FAIL sim_ld_mtval: got %h exp 1003", mtval_o); end
    vec_cnt++; if (set_mtval_o !== 1'b1) begin err_cnt++; $display("FAIL sim_ld_setmtval: got %h exp 1", set_mtval_o); end
    tick();
    exception_i = 8'h0A; pc_i = 32'hB0;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (trap_cause_o !== 5'd0) begin err_cnt++; $display("FAIL sim_mi_cause: got %0d exp 0", trap_cause_o); end
    vec_cnt++; if (mtval_o !== 32'hB0) begin err_cnt++; $display("FAIL sim_mi_mtval: got %h exp b0", mtval_o); end
    tick();
  endtask

  task automatic test_mret();
    epc_i = 32'h400; exception_i = 8'h01;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL mret_flush: got %h exp 1", flush_o); end
    vec_cnt++; if (new_pc_o !== 32'h400) begin err_cnt++; $display("FAIL mret_newpc: got %h exp 400", new_pc_o); end
    vec_cnt++; if (mstatus_ie_set_o !== 1'b1) begin err_cnt++; $display("FAIL mret_ieset: got %h exp 1", mstatus_ie_set_o); end
    vec_cnt++; if (set_cause_o !== 1'b0) begin err_cnt++; $display("FAIL mret_setcause: got %h exp 0", set_cause_o); end
    tick();
    vec_cnt++; if (mstatus_ie_set_o !== 1'b0) begin err_cnt++; $display("FAIL mret_ieset_after: got %h exp 0", mstatus_ie_set_o); end
    vec_cnt++; if (flush_o !== 1'b0) begin err_cnt++; $display("FAIL mret_flush_after: got %h exp 0", flush_o); end
  endtask

  task automatic test_stall();
    logic [3:0] req [5] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [5:0] exp [5] = '{6'b011111, 6'b001111, 6'b000111, 6'b000111, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req[i];
      #1;
      vec_cnt++; if (stall_o !== exp[i]) begin err_cnt++; $display("FAIL stall_%0d: got %b exp %b", i, stall_o, exp[i]); end
    end
    stallreq_mem_i = 1'b1; exception_i = 8'h02;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (stall_o !== 6'b0) begin err_cnt++; $display("FAIL stall_trap: got %b exp 000000", stall_o); end
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL stall_trap_flush: got %h exp 1", flush_o); end
    stallreq_mem_i = 1'b0;
    tick();
  endtask

  task automatic test_wfi();
    exception_i = 8'h80;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (stall_o !== 6'b011111) begin err_cnt++; $display("FAIL wfi_stall: got %b exp 011111", stall_o); end
    vec_cnt++; if (wfi_sleep_o !== 1'b1) begin err_cnt++; $display("FAIL wfi_sleep: got %h exp 1", wfi_sleep_o); end
    tick();
    vec_cnt++; if (wfi_sleep_o !== 1'b1) begin err_cnt++; $display("FAIL wfi_hold: got %h exp 1", wfi_sleep_o); end
    mie_i = 20'h80; mip_i = 20'h80; mstatus_ie_i = 1'b0;
    tick();
    vec_cnt++; if (wfi_sleep_o !== 1'b0) begin err_cnt++; $display("FAIL wfi_wake0: got %h exp 0", wfi_sleep_o); end
    tick();
    vec_cnt++; if (flush_o !== 1'b0) begin err_cnt++; $display("FAIL wfi_notrap: got %h exp 0", flush_o); end
    mip_i = '0;
    exception_i = 8'h80;
    tick();
    exception_i = 8'h00;
    vec_cnt++; if (wfi_sleep_o !== 1'b1) begin err_cnt++; $display("FAIL wfi_sleep2: got %h exp 1", wfi_sleep_o); end
    mip_i = 20'h80; mstatus_ie_i = 1'b1; pc_i = 32'hC0;
    tick();
    vec_cnt++; if (wfi_sleep_o !== 1'b0 || flush_o !== 1'b0) begin err_cnt++; $display("FAIL wfi_wake1: got sleep %h flush %h exp 0 0", wfi_sleep_o, flush_o); end
    tick();
    mstatus_ie_i = 1'b0; mip_i = '0; mie_i = '0;
    vec_cnt++; if (flush_o !== 1'b1) begin err_cnt++; $display("FAIL wfi_trap_flush: got %h exp 1", flush_o); end
    vec_cnt++; if (trap_cause_o !== 5'd7) begin err_cnt++; $display("FAIL wfi_trap_cause: got %0d exp 7", trap_cause_o); end
    vec_cnt++; if (ie_type_o !== 1'b1) begin err_cnt++; $display("FAIL wfi_trap_ietype: got %h exp 1", ie_type_o); end
    vec_cnt++; if (new_pc_o !== 32'h21C) begin err_cnt++; $display("FAIL wfi_trap_newpc: got %h exp 21c", new_pc_o); end
    tick();
  endtask

  initial begin
    rst_i = 1'b1; exception_i = '0; pc_i = '0; ins_i = '0; mem_addr_i = '0;
    mtvec_i = '0; epc_i = '0; stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0;
    stallreq_mem_i = 0; mstatus_ie_i = 0; mie_i = '0; mip_i = '0;
    tick();
    tick();
    test_reset();
    test_direct();
    test_vectored();
    test_simultaneous();
    test_mret();
    test_stall();
    test_wfi();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised next-generation pipeline control and trap unit for the RV32 core.
- Arbitrates stall requests from IF/ID/EX/MEM and sequences traps into and out of machine mode.
- Adds NUM_LOCAL_IRQ platform interrupts (mcause 16+k), a fixed RISC-V interrupt/exception priority, mtval for misaligned data addresses, and a WFI sleep state.
- Drives the CSR unit's update strobes and the IFU's redirect (flush_o/new_pc_o).

Parameters:
XLEN, 32, data/address width
NUM_LOCAL_IRQ, 4, local interrupt lines (0..16), mapped to mie/mip bits 16+k, cause 16+k
RESET_PC, 32'h0000_0000, fetch address issued after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
exception_i  in  8  {wfi, misaligned_load, misaligned_store, illegal_inst, misaligned_inst, ebreak, ecall, mret}
pc_i  in  XLEN  PC of the instruction carrying exception_i
ins_i  in  XLEN  instruction word
mem_addr_i  in  XLEN  effective load/store address
stallreq_if_i / stallreq_id_i / stallreq_ex_i / stallreq_mem_i  in  1 each  stall requests
mstatus_ie_i  in  1  global MIE
mie_i  in  16+NUM_LOCAL_IRQ  interrupt enables
mip_i  in  16+NUM_LOCAL_IRQ  interrupt pending
mtvec_i  in  XLEN  trap vector {base, mode}
epc_i  in  XLEN  current mepc
ie_type_o  out  1  1 = interrupt, 0 = exception
set_cause_o  out  1  write mcause
trap_cause_o  out  5  mcause code
set_epc_o  out  1  write mepc
epc_o  out  XLEN  mepc value
set_mtval_o  out  1  write mtval
mtval_o  out  XLEN  mtval value
mstatus_ie_clear_o / mstatus_ie_set_o  out  1 each  MIE clear/set strobes
stall_o  out  6  per-stage stall: bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 spare
flush_o  out  1  flush pipeline
new_pc_o  out  XLEN  redirect PC (valid with flush_o)
wfi_sleep_o  out  1  core sleeping

Behaviour:
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN, WFI. rst_i forces RESET immediately.
- Reset values: all registered outputs are 0, and mtval_o/epc_o are 0.
- Pending interrupts: ip = mie_i & mip_i. An interrupt is taken only when mstatus_ie_i=1.
- Interrupt priority: highest local k first (cause 16+k), then external (11), software (3), timer (7).
- Exception priority: misaligned_inst (0) > illegal_inst (2) > ebreak (3) > ecall (11) > misaligned_load (4) > misaligned_store (6).
- Interrupts take priority over exceptions.
- trap = taken interrupt | any exception bit.

State transitions:
- RESET -> OPERATING.
- OPERATING: trap -> TRAP_TAKEN; else mret -> TRAP_RETURN; else wfi -> WFI; else stay. trap beats mret, and mret beats wfi.
- TRAP_TAKEN and TRAP_RETURN -> OPERATING after one cycle.
- WFI -> OPERATING when |ip, regardless of mstatus_ie_i. A taken interrupt then follows through OPERATING.

Latching on OPERATING->TRAP_TAKEN (registered):
- ie_type_o, trap_cause_o, epc_o <= pc_i.
- mtval_o and set_mtval_o:
  - pc_i for misaligned_inst / ebreak
  - ins_i for illegal_inst
  - mem_addr_i for misaligned_load / misaligned_store
  - 0 with set_mtval_o=0 for ecall and interrupts
- Latched values hold until the next trap.

Outputs per state (combinational, 1 cycle):
- TRAP_TAKEN: flush_o=1, set_cause_o=1, set_epc_o=1, mstatus_ie_clear_o=1, set_mtval_o as latched. new_pc_o = {mtvec_i[XLEN-1:2],2'b00}, plus trap_cause_o*4 when mtvec_i[0]=1 and ie_type_o=1.
- TRAP_RETURN: flush_o=1, new_pc_o=epc_i, mstatus_ie_set_o=1.
- RESET: flush_o=1, new_pc_o=RESET_PC.
- Otherwise all strobes are 0 and new_pc_o=0.
- set_mtval_o is 0 outside TRAP_TAKEN.

Latency: trap detected in cycle N; strobes and redirect in N+1; fetch from the new PC in N+2.

Stall arbitration (combinational):
- RESET, TRAP_TAKEN, TRAP_RETURN: stall_o=0.
- WFI: stall_o=6'b011111 and wfi_sleep_o=1.
- OPERATING, by priority:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000111
  - none: 0
- Traps are taken even while stall requests are active, and flush overrides the stall.

Widths and aliasing:
- Bits 15:12, 10, 9, 8, 6, 5, 4, 2, 1, 0 of mie_i/mip_i are ignored.
- With NUM_LOCAL_IRQ=0 only 16 bits are used.

Test Plan:
- Reset: assert rst_i mid-trap -> state RESET and all strobes 0 immediately; first cycle after release flush_o=1, new_pc_o=RESET_PC; next cycle flush_o=0.
- Direct mode: mtvec_i=32'h100, illegal_inst with pc_i=32'h80, ins_i=32'hFFFFFFFF -> next cycle flush_o=1, new_pc_o=32'h100, trap_cause_o=2, epc_o=32'h80, mtval_o=32'hFFFFFFFF, mstatus_ie_clear_o=1.
- Vectored priority: mtvec_i=32'h201, mstatus_ie_i=1, mip/mie bits 7, 11, 17 all set -> cause 17, ie_type_o=1, new_pc_o=32'h244. With mstatus_ie_i=0 -> no trap.
- Simultaneous: ecall+mret in the same cycle -> TRAP_TAKEN with cause 11. misaligned_load with mem_addr_i=32'h1003 -> cause 4, mtval_o=32'h1003.
- mret: epc_i=32'h400 -> flush_o=1, new_pc_o=32'h400, mstatus_ie_set_o=1 for exactly one cycle.
- WFI: wfi with no pending interrupt -> stall_o=6'b011111, wfi_sleep_o=1 held. Raise mip bit 7 with mie bit 7 set and mstatus_ie_i=0 -> back to OPERATING with no trap. With mstatus_ie_i=1 -> wake, then trap with cause 7.
